fetch_stage: RTL and testbench

- Instruction-fetch stage: owns the PC register, issues requests to instruction memory, and drives the IF/ID pipeline register that feeds the decode stage and the branch processor (o_if_pc/o_if_instr become its current-PC/instruction inputs).
- Consumes the branch processor's is-branch/next-PC result to redirect fetch after the branch delay slot.
- Absorbs memory wait states and decode stalls with a one-entry skid buffer.

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem request, IF/ID pipeline register,
// one-entry skid buffer and delayed-branch redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_id_is_branch,
  input  logic [31:0] i_id_next_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic        o_if_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_pending_q, redir_pending_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;

  logic complete;
  logic branch_leaving;

  assign o_imem_req     = (state_q == FETCH);
  assign o_imem_addr    = pc_q;
  assign o_if_pc        = if_pc_q;
  assign o_if_instr     = if_instr_q;
  assign o_if_valid     = if_valid_q;
  assign complete       = o_imem_req && i_imem_ready;
  assign branch_leaving = !i_stall && if_valid_q && i_id_is_branch;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    redir_pc_d      = redir_pc_q;
    redir_pending_d = redir_pending_q;
    buf_pc_d        = buf_pc_q;
    buf_instr_d     = buf_instr_q;
    if_pc_d         = if_pc_q;
    if_instr_d      = if_instr_q;
    if_valid_d      = if_valid_q;

    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (complete) begin
          // The completing fetch is the delay slot when a branch leaves ID now
          if (branch_leaving)       pc_d = i_id_next_pc;
          else if (redir_pending_q) pc_d = redir_pc_q;
          else                      pc_d = pc_q + 32'd4;
          redir_pending_d = 1'b0;
          if (!i_stall) begin
            if_pc_d    = pc_q;
            if_instr_d = i_imem_rdata;
            if_valid_d = 1'b1;
          end else begin
            buf_pc_d    = pc_q;
            buf_instr_d = i_imem_rdata;
            state_d     = HOLD;
          end
        end else begin
          if (branch_leaving) begin
            redir_pc_d      = i_id_next_pc;
            redir_pending_d = 1'b1;
          end
          if (!i_stall) if_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (branch_leaving) pc_d = i_id_next_pc;
        if (!i_stall) begin
          if_pc_d    = buf_pc_q;
          if_instr_d = buf_instr_q;
          if_valid_d = 1'b1;
          state_d    = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase

    // Flush wins over stall, redirect and any same-cycle completion
    if (i_flush && state_q != BOOT) begin
      pc_d            = i_flush_pc;
      redir_pending_d = 1'b0;
      if_pc_d         = if_pc_q;
      if_instr_d      = if_instr_q;
      if_valid_d      = 1'b0;
      state_d         = FETCH;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      redir_pc_q      <= 32'd0;
      redir_pending_q <= 1'b0;
      buf_pc_q        <= 32'd0;
      buf_instr_q     <= 32'd0;
      if_pc_q         <= 32'd0;
      if_instr_q      <= 32'd0;
      if_valid_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      redir_pc_q      <= redir_pc_d;
      redir_pending_q <= redir_pending_d;
      buf_pc_q        <= buf_pc_d;
      buf_instr_q     <= buf_instr_d;
      if_pc_q         <= if_pc_d;
      if_instr_q      <= if_instr_d;
      if_valid_q      <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns addr ^ KEY.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, is_branch, ready;
  logic [31:0] flush_pc, next_pc;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_instr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_flush_pc(flush_pc), .i_id_is_branch(is_branch), .i_id_next_pc(next_pc),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .i_imem_ready(ready), .o_if_pc(if_pc), .o_if_instr(if_instr), .o_if_valid(if_valid)
  );

  // Leaves the bench at the first negedge after release (DUT still in BOOT)
  task do_reset;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 32'd0;
    is_branch = 1'b0; next_pc = 32'd0; ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Flushes to 0x200 and returns with IF/ID = 0x200 and addr = 0x204
  task goto_200;
    do_reset;
    @(negedge clk);
    flush = 1'b1; flush_pc = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task test_reset;
    do_reset;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL boot_req got=%b exp=0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("[TB] FAIL boot_valid got=%b exp=0", if_valid); end
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_valid got=%b exp=0", if_valid); end
    checks++; if (if_pc !== 32'd0) begin failures++; $display("[TB] FAIL async_pc got=%h exp=%h", if_pc, 32'd0); end
    checks++; if (if_instr !== 32'd0) begin failures++; $display("[TB] FAIL async_instr got=%h exp=%h", if_instr, 32'd0); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL async_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL async_addr got=%h exp=%h", imem_addr, 32'h100); end
  endtask

  task test_sequential;
    do_reset;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL seq_first req=%b addr=%h exp 1/%h", imem_req, imem_addr, 32'h100); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("[TB] FAIL seq_valid0 got=%b exp=0", if_valid); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h104) begin failures++; $display("[TB] FAIL seq_addr1 got=%h exp=%h", imem_addr, 32'h104); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin failures++; $display("[TB] FAIL seq_if0 valid=%b pc=%h exp 1/%h", if_valid, if_pc, 32'h100); end
    checks++; if (if_instr !== (32'h100 ^ KEY)) begin failures++; $display("[TB] FAIL seq_instr0 got=%h exp=%h", if_instr, 32'h100 ^ KEY); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h108 || if_pc !== 32'h104) begin failures++; $display("[TB] FAIL seq_step2 addr=%h pc=%h exp %h/%h", imem_addr, if_pc, 32'h108, 32'h104); end
  endtask

  task test_wait_states;
    do_reset;
    @(negedge clk); @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (imem_addr !== 32'h104 || imem_req !== 1'b1) begin failures++; $display("[TB] FAIL wait_addr%0d addr=%h req=%b exp %h/1", i, imem_addr, imem_req, 32'h104); end
      checks++; if (if_valid !== 1'b0 || if_pc !== 32'h100) begin failures++; $display("[TB] FAIL wait_bubble%0d valid=%b pc=%h exp 0/%h", i, if_valid, if_pc, 32'h100); end
    end
    ready = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104 || imem_addr !== 32'h108) begin failures++; $display("[TB] FAIL wait_done valid=%b pc=%h addr=%h exp 1/%h/%h", if_valid, if_pc, imem_addr, 32'h104, 32'h108); end
  endtask

  task test_stall_hold;
    do_reset;
    @(negedge clk); @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL hold_req%0d got=%b exp=0", i, imem_req); end
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin failures++; $display("[TB] FAIL hold_frozen%0d valid=%b pc=%h exp 1/%h", i, if_valid, if_pc, 32'h100); end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_instr !== (32'h104 ^ KEY)) begin failures++; $display("[TB] FAIL hold_release pc=%h instr=%h exp %h/%h", if_pc, if_instr, 32'h104, 32'h104 ^ KEY); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin failures++; $display("[TB] FAIL hold_resume req=%b addr=%h exp 1/%h", imem_req, imem_addr, 32'h108); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h108 || imem_addr !== 32'h10C) begin failures++; $display("[TB] FAIL hold_next pc=%h addr=%h exp %h/%h", if_pc, imem_addr, 32'h108, 32'h10C); end
  endtask

  task test_branch(input logic [31:0] target);
    goto_200;
    checks++; if (if_pc !== 32'h200 || if_valid !== 1'b1 || imem_addr !== 32'h204) begin failures++; $display("[TB] FAIL br_setup pc=%h valid=%b addr=%h exp %h/1/%h", if_pc, if_valid, imem_addr, 32'h200, 32'h204); end
    is_branch = 1'b1; next_pc = target;
    @(negedge clk);
    is_branch = 1'b0;
    checks++; if (if_pc !== 32'h204 || imem_addr !== target) begin failures++; $display("[TB] FAIL br_slot pc=%h addr=%h exp %h/%h", if_pc, imem_addr, 32'h204, target); end
    @(negedge clk);
    checks++; if (if_pc !== target || if_valid !== 1'b1) begin failures++; $display("[TB] FAIL br_target pc=%h valid=%b exp %h/1", if_pc, if_valid, target); end
  endtask

  task test_branch_wait;
    goto_200;
    is_branch = 1'b1; next_pc = 32'h500; ready = 1'b0;
    @(negedge clk);
    is_branch = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h204) begin failures++; $display("[TB] FAIL brw_wait valid=%b addr=%h exp 0/%h", if_valid, imem_addr, 32'h204); end
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    checks++; if (if_pc !== 32'h204 || if_valid !== 1'b1 || imem_addr !== 32'h500) begin failures++; $display("[TB] FAIL brw_redirect pc=%h valid=%b addr=%h exp %h/1/%h", if_pc, if_valid, imem_addr, 32'h204, 32'h500); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h500) begin failures++; $display("[TB] FAIL brw_target got=%h exp=%h", if_pc, 32'h500); end
  endtask

  task test_flush_hold;
    do_reset;
    @(negedge clk); @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    flush = 1'b1; flush_pc = 32'h80;
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h80 || imem_req !== 1'b1) begin failures++; $display("[TB] FAIL flh_flush valid=%b addr=%h req=%b exp 0/%h/1", if_valid, imem_addr, imem_req, 32'h80); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h80 || if_valid !== 1'b1 || imem_addr !== 32'h84) begin failures++; $display("[TB] FAIL flh_resume pc=%h valid=%b addr=%h exp %h/1/%h", if_pc, if_valid, imem_addr, 32'h80, 32'h84); end
  endtask

  task test_flush_pending;
    goto_200;
    is_branch = 1'b1; next_pc = 32'h500; ready = 1'b0;
    @(negedge clk);
    is_branch = 1'b0; ready = 1'b1; flush = 1'b1; flush_pc = 32'h80;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h80) begin failures++; $display("[TB] FAIL flp_flush valid=%b addr=%h exp 0/%h", if_valid, imem_addr, 32'h80); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h80 || imem_addr !== 32'h84) begin failures++; $display("[TB] FAIL flp_nopend pc=%h addr=%h exp %h/%h", if_pc, imem_addr, 32'h80, 32'h84); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_wait_states;
    test_stall_hold;
    test_branch(32'h400);
    test_branch(32'h208);
    test_branch_wait;
    test_flush_hold;
    test_flush_pending;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
